// File: rtl/burst_memory_responder_pkg.sv
// Shared types and constants for the burst memory responder and its line store.
package burst_mem_types;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BURST,
      DONE
   } state_t;

   localparam int BEATS       = 4;
   localparam int BEAT_W      = 64;
   localparam int LINE_W      = BEATS * BEAT_W;
   localparam int OFFSET_BITS = 5;
   localparam int BEAT_IDX_W  = 2;

   function automatic logic is_last_beat(input logic [BEAT_IDX_W-1:0] beat);
      return beat == BEAT_IDX_W'(BEATS - 1);
   endfunction

endpackage

// File: rtl/burst_memory_responder_array.sv
// Line store: DEPTH_LINES lines of four 64-bit beats, beat-granular write port
// and a registered beat read port that returns zero when not enabled.
module burst_mem_array
   import burst_mem_types::*;
#(
   parameter int DEPTH_LINES = 256,
   localparam int IDX_W = $clog2(DEPTH_LINES)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [IDX_W-1:0]      idx,
   input  logic                  wr_en,
   input  logic [BEAT_IDX_W-1:0] wr_beat,
   input  logic [BEAT_W-1:0]     wdata,
   input  logic                  rd_en,
   input  logic [BEAT_IDX_W-1:0] rd_beat,
   output logic [BEAT_W-1:0]     rdata
);

   logic [BEATS-1:0][BEAT_W-1:0] mem [DEPTH_LINES];

   // Storage is deliberately not reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[idx][wr_beat] <= wdata;
      end
   end

   // Registered read beat, forced to zero whenever no read beat is due next cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata <= '0;
      end else if (rd_en) begin
         rdata <= mem[idx][rd_beat];
      end else begin
         rdata <= '0;
      end
   end

endmodule

// File: rtl/burst_memory_responder.sv
// Burst memory responder: serves 256-bit lines as four 64-bit beats after a
// fixed latency. Optional protocol checker enabled by BURST_MEM_PROTOCOL_CHECK_EN.
module burst_memory_responder
   import burst_mem_types::*;
#(
   parameter int LATENCY     = 4,
   parameter int DEPTH_LINES = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [31:0]       pmem_addr,
   input  logic [BEAT_W-1:0] pmem_wdata,
   output logic              pmem_resp,
   output logic [BEAT_W-1:0] pmem_rdata,
   output logic              protocol_err
);

   localparam int IDX_W = $clog2(DEPTH_LINES);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t                state;
   state_t                next_state;
   logic [CNT_W-1:0]      lat_cnt;
   logic [CNT_W-1:0]      next_cnt;
   logic [BEAT_IDX_W-1:0] beat;
   logic [BEAT_IDX_W-1:0] next_beat;
   logic [IDX_W-1:0]      line_idx;
   logic                  op_write;
   logic                  accept;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^{pmem_addr[31:OFFSET_BITS+IDX_W], pmem_addr[OFFSET_BITS-1:0]};

   // Next-state logic: accept, count down latency, walk four beats, turn around.
   always_comb begin
      next_state = state;
      next_cnt   = lat_cnt;
      next_beat  = beat;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (pmem_read || pmem_write) begin
               accept     = 1'b1;
               next_cnt   = CNT_W'(LATENCY - 1);
               next_state = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt == '0) begin
               next_state = BURST;
               next_beat  = '0;
            end else begin
               next_cnt = lat_cnt - 1'b1;
            end
         end
         BURST: begin
            if (is_last_beat(beat)) begin
               next_state = DONE;
               next_beat  = '0;
            end else begin
               next_beat = beat + 1'b1;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State, counters, latched request and the registered beat strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         lat_cnt   <= '0;
         beat      <= '0;
         line_idx  <= '0;
         op_write  <= 1'b0;
         pmem_resp <= 1'b0;
      end else begin
         state     <= next_state;
         lat_cnt   <= next_cnt;
         beat      <= next_beat;
         pmem_resp <= (next_state == BURST);
         if (accept) begin
            line_idx <= pmem_addr[OFFSET_BITS +: IDX_W];
            op_write <= ~pmem_read;
         end
      end
   end

   burst_mem_array #(
      .DEPTH_LINES (DEPTH_LINES)
   ) u_array (
      .clk     (clk),
      .reset_n (reset_n),
      .idx     (line_idx),
      .wr_en   ((state == BURST) && op_write),
      .wr_beat (beat),
      .wdata   (pmem_wdata),
      .rd_en   ((next_state == BURST) && !op_write),
      .rd_beat (next_beat),
      .rdata   (pmem_rdata)
   );

`ifdef BURST_MEM_PROTOCOL_CHECK_EN
   logic [31:0] addr_prev;
   logic        busy;
   logic        both_req;
   logic        req_dropped;
   logic        addr_moved;

   assign busy        = (state == WAIT) || (state == BURST);
   assign both_req    = pmem_read && pmem_write;
   assign req_dropped = busy && (op_write ? !pmem_write : !pmem_read);
   assign addr_moved  = busy && (pmem_addr != addr_prev);

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_prev    <= '0;
         protocol_err <= 1'b0;
      end else begin
         addr_prev <= pmem_addr;
         if (both_req || req_dropped || addr_moved) begin
            protocol_err <= 1'b1;
         end
      end
   end

`ifndef SYNTHESIS
   // Report each protocol event as it happens in simulation.
   always @(posedge clk) begin
      if (reset_n) begin
         if (both_req)    $error("burst_memory_responder: read and write both high");
         if (req_dropped) $error("burst_memory_responder: request dropped before last beat");
         if (addr_moved)  $error("burst_memory_responder: address changed during transaction");
      end
   end
`endif
`else
   assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_memory_responder.sv
// Scoreboard bench: two responders (LATENCY 4 / 256 lines and LATENCY 1 / 4 lines);
// stimulus pushes expected beats, a negedge monitor pops and compares them.
module tb_burst_memory_responder;

   typedef logic [63:0] line_t [4];

   localparam int LAT0 = 4;
   localparam int LAT1 = 1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        rd    [2];
   logic        wr    [2];
   logic [31:0] addr  [2];
   logic [63:0] wdata [2];
   logic        resp  [2];
   logic [63:0] rdata [2];
   logic        err   [2];

   int          checks = 0;
   int          fails  = 0;
   logic [63:0] q0 [$];
   logic [63:0] q1 [$];
   logic        exp_err;

   line_t lineA = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
   line_t lineW = '{64'hA5A5A5A500000001, 64'hA5A5A5A500000002, 64'hA5A5A5A500000003, 64'hA5A5A5A500000004};
   line_t lineO = '{64'h0D0D0D0D0D0D0D00, 64'h0D0D0D0D0D0D0D01, 64'h0D0D0D0D0D0D0D02, 64'h0D0D0D0D0D0D0D03};
   line_t lineN = '{64'hBEEF00000000BEE0, 64'hBEEF00000000BEE1, 64'hBEEF00000000BEE2, 64'hBEEF00000000BEE3};
   line_t lineM = '{64'hBEEF00000000BEE0, 64'hBEEF00000000BEE1, 64'h0D0D0D0D0D0D0D02, 64'h0D0D0D0D0D0D0D03};
   line_t lineP = '{64'hCAFE0000000000F0, 64'hCAFE0000000000F1, 64'hCAFE0000000000F2, 64'hCAFE0000000000F3};

   always #5 clk = ~clk;

   burst_memory_responder #(.LATENCY(LAT0), .DEPTH_LINES(256)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .pmem_read    (rd[0]),
      .pmem_write   (wr[0]),
      .pmem_addr    (addr[0]),
      .pmem_wdata   (wdata[0]),
      .pmem_resp    (resp[0]),
      .pmem_rdata   (rdata[0]),
      .protocol_err (err[0])
   );

   burst_memory_responder #(.LATENCY(LAT1), .DEPTH_LINES(4)) dut1 (
      .clk          (clk),
      .reset_n      (reset_n),
      .pmem_read    (rd[1]),
      .pmem_write   (wr[1]),
      .pmem_addr    (addr[1]),
      .pmem_wdata   (wdata[1]),
      .pmem_resp    (resp[1]),
      .pmem_rdata   (rdata[1]),
      .protocol_err (err[1])
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic pushExp(input int sel, input logic [63:0] v);
      if (sel == 0) q0.push_back(v);
      else          q1.push_back(v);
   endtask

   task automatic waitFirstResp(input int sel, input int expected);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp[sel] && n < 40);
      checkOutput("first_resp_cycle", 64'(n), 64'(expected));
   endtask

   // One full transaction; d is write data, or the line expected back on a read.
   task automatic applyStimulus(input int sel, input bit is_write, input bit both,
                                input logic [31:0] a, input line_t d);
      bit reads;
      reads = !is_write || both;
      @(negedge clk);
      for (int b = 0; b < 4; b++) pushExp(sel, reads ? d[b] : 64'h0);
      addr[sel]  = a;
      rd[sel]    = reads;
      wr[sel]    = is_write || both;
      wdata[sel] = d[0];
      waitFirstResp(sel, (sel == 0 ? LAT0 : LAT1) + 1);
      for (int b = 1; b < 4; b++) begin
         @(posedge clk);
         #1;
         wdata[sel] = d[b];
         @(negedge clk);
         checkOutput("resp_beat", 64'(resp[sel]), 64'h1);
      end
      @(posedge clk);
      #1;
      rd[sel] = 1'b0;
      wr[sel] = 1'b0;
      @(negedge clk);
      checkOutput("resp_done", 64'(resp[sel]), 64'h0);
   endtask

   // Read held high across two transactions: 4 beats, DONE, IDLE accept, LATENCY wait.
   task automatic backToBack(input logic [31:0] a, input line_t d);
      int n;
      @(negedge clk);
      for (int k = 0; k < 8; k++) pushExp(0, d[k % 4]);
      addr[0] = a;
      rd[0]   = 1'b1;
      waitFirstResp(0, LAT0 + 1);
      for (int b = 1; b < 4; b++) begin
         @(negedge clk);
         checkOutput("b2b_beat_a", 64'(resp[0]), 64'h1);
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp[0] && n < 40);
      checkOutput("b2b_gap", 64'(n), 64'(LAT0 + 3));
      for (int b = 1; b < 4; b++) begin
         @(negedge clk);
         checkOutput("b2b_beat_b", 64'(resp[0]), 64'h1);
      end
      @(posedge clk);
      #1;
      rd[0] = 1'b0;
      @(negedge clk);
      checkOutput("b2b_done", 64'(resp[0]), 64'h0);
   endtask

   // Write interrupted by reset just after beat 1 commits.
   task automatic resetMidWrite(input logic [31:0] a, input line_t d);
      @(negedge clk);
      pushExp(0, 64'h0);
      pushExp(0, 64'h0);
      addr[0]  = a;
      wr[0]    = 1'b1;
      wdata[0] = d[0];
      waitFirstResp(0, LAT0 + 1);
      @(posedge clk);
      #1;
      wdata[0] = d[1];
      @(negedge clk);
      checkOutput("rst_beat1", 64'(resp[0]), 64'h1);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      wr[0]   = 1'b0;
      #1;
      checkOutput("rst_resp", 64'(resp[0]), 64'h0);
      checkOutput("rst_rdata", rdata[0], 64'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      checkOutput("queue_after_reset", 64'(q0.size()), 64'h0);
   endtask

   // Monitor: pop an expected beat for every resp cycle, rdata must be 0 otherwise.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!resp[i]) begin
            checkOutput("rdata_idle", rdata[i], 64'h0);
         end else if (reset_n) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
               checks++;
               fails++;
               $display("[TB] FAIL unexpected_resp dut%0d actual=1 required=0", i);
            end else if (i == 0) begin
               checkOutput("rdata_dut0", rdata[0], q0.pop_front());
            end else begin
               checkOutput("rdata_dut1", rdata[1], q1.pop_front());
            end
         end
      end
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
`ifdef BURST_MEM_PROTOCOL_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      reset_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd[i]    = 1'b0;
         wr[i]    = 1'b0;
         addr[i]  = 32'h0;
         wdata[i] = 64'h0;
      end
      #2;
      checkOutput("reset_resp", 64'(resp[0]), 64'h0);
      checkOutput("reset_rdata", rdata[0], 64'h0);
      checkOutput("reset_err", 64'(err[0]), 64'h0);
      checkOutput("reset_resp1", 64'(resp[1]), 64'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      $display("[TB] write then read line 0x40");
      applyStimulus(0, 1'b1, 1'b0, 32'h00000040, lineA);
      applyStimulus(0, 1'b0, 1'b0, 32'h00000040, lineA);

      $display("[TB] address wrap 0x2000 -> 0x0");
      applyStimulus(0, 1'b1, 1'b0, 32'h00002000, lineW);
      applyStimulus(0, 1'b0, 1'b0, 32'h00000000, lineW);
      applyStimulus(0, 1'b0, 1'b0, 32'h0000005F, lineA);

      $display("[TB] back-to-back reads");
      backToBack(32'h00000040, lineA);

      $display("[TB] reset during write");
      applyStimulus(0, 1'b1, 1'b0, 32'h00000080, lineO);
      resetMidWrite(32'h00000080, lineN);
      applyStimulus(0, 1'b0, 1'b0, 32'h00000080, lineM);

      $display("[TB] read and write together");
      applyStimulus(0, 1'b1, 1'b1, 32'h00000040, lineA);
      checkOutput("protocol_err_set", 64'(err[0]), 64'(exp_err));
      repeat (3) @(negedge clk);
      checkOutput("protocol_err_sticky", 64'(err[0]), 64'(exp_err));
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      checkOutput("protocol_err_cleared", 64'(err[0]), 64'h0);

      $display("[TB] LATENCY=1 instance");
      applyStimulus(1, 1'b1, 1'b0, 32'h00000020, lineP);
      applyStimulus(1, 1'b0, 1'b0, 32'h00000020, lineP);
      applyStimulus(1, 1'b0, 1'b0, 32'h000000A0, lineP);

      repeat (2) @(negedge clk);
      checkOutput("queue0_empty", 64'(q0.size()), 64'h0);
      checkOutput("queue1_empty", 64'(q1.size()), 64'h0);
      checkOutput("final_err0", 64'(err[0]), 64'h0);
      checkOutput("final_err1", 64'(err[1]), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
